cmp_stim_checker: RTL
=====================

CMP_STIM_CHECKER -- requirements
Module: cmp_stim_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width driven to the comparator.
REQ-002 SHALL have parameter SETTLE, default 1, range 1..15, cycles each operand pair is held before its result is sampled.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a sweep; honoured only in IDLE or DONE.
REQ-007 a_out  output  WIDTH  operand a driven to the comparator under test.
REQ-008 b_out  output  WIDTH  operand b driven to the comparator under test.
REQ-009 eq_in, neq_in, big_a_in, big_b_in  input  1 each  comparator responses.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high in DONE until the next start.
REQ-012 pass  output  1  done and zero errors.
REQ-013 err_cnt  output  2*WIDTH+1  number of mismatching pairs in the current or last sweep.
REQ-014 first_err_a, first_err_b  output  WIDTH each  operands of the first mismatching pair; 0 if none.

Function
REQ-015 SHALL implement states IDLE, DRIVE, CHECK and DONE.
REQ-016 IDLE or DONE with start=1 SHALL clear err_cnt, first_err_*, a_out and b_out, then enter DRIVE.
REQ-017 DRIVE SHALL hold a_out/b_out for exactly SETTLE cycles, then enter CHECK.
REQ-018 CHECK SHALL last one cycle and sample eq_in, neq_in, big_a_in and big_b_in against expected values.
- Expected values: eq = (a==b), neq = (a!=b), big_a = (a>b), big_b = (b>a), all unsigned.
REQ-019 A pair SHALL count as a mismatch if any of the four bits differs; each mismatch increments err_cnt by 1.
REQ-020 first_err_* SHALL be captured only on the first mismatch of a sweep.
REQ-021 Sweep order SHALL be a outer, b inner, both from 0 to 2^WIDTH-1; b wraps to 0 as a increments.
REQ-022 After CHECK, the block SHALL advance to the next pair and return to DRIVE.
- After pair (max,max) it SHALL enter DONE instead.
REQ-023 Sweep length SHALL be 2^(2*WIDTH)*(SETTLE+1) cycles from the start cycle to DONE entry.
- WIDTH=4, SETTLE=1: 512 cycles.
REQ-024 start while busy SHALL be ignored.
REQ-025 start in DONE SHALL restart the sweep immediately.
REQ-026 err_cnt SHALL NOT saturate; its width covers the all-fail case (2^(2*WIDTH)).
REQ-027 busy SHALL be 1 exactly in DRIVE and CHECK.
REQ-028 done SHALL be 1 exactly in DONE.
REQ-029 pass SHALL equal done AND (err_cnt==0).
REQ-030 All outputs SHALL be registered, with no combinational path from the *_in ports to any output.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE and set every output to 0: a_out, b_out, busy, done, pass, err_cnt and first_err_*.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no partial result retained.
- After rst_n rises, a new start is required.

Structure
REQ-033 Shared package cmp_pkg SHALL hold the state encoding typedef and the WIDTH/SETTLE defaults.
REQ-034 The expected-value computation SHALL be a combinational sub-module, cmp_ref_model (inputs a, b; outputs eq, neq, big_a, big_b).
- cmp_ref_model is reusable as a golden model in benches.
REQ-035 The settle counter and the a/b sweep counters SHALL be separate registers inside cmp_stim_checker.

Verification
REQ-036 Correct 4-bit comparator attached, start pulse -> done at cycle 512, err_cnt=0, pass=1.
REQ-037 Comparator with big_a stuck at 0 -> err_cnt=120, first_err_a=1, first_err_b=0, pass=0.
REQ-038 Comparator with eq inverted -> err_cnt=256, first_err_a=0, first_err_b=0.
REQ-039 rst_n pulsed low at cycle 100 of a sweep -> all outputs 0 within the same cycle, state IDLE.
- A new start then gives a full 512-cycle sweep.
REQ-040 start held high throughout the sweep -> single sweep, no restart while busy.
- Restart occurs on the first cycle in DONE.
REQ-041 SETTLE=3 with a correct comparator -> done at cycle 1024, each pair held 3 cycles, pass=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator stimulus/checker: sweep states and parameter defaults.
// Pure declarations, no logic.
package cmp_pkg;

    localparam int unsigned CMP_WIDTH_DEF  = 4;
    localparam int unsigned CMP_SETTLE_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } cmp_state_e;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden unsigned comparator: the responses a correct DUT must give for operands a and b.
// Purely combinational, zero latency; usable as a reference model in benches.
module cmp_ref_model
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             neq,
    output logic             big_a,
    output logic             big_b
);

    assign eq    = (a == b);
    assign neq   = (a != b);
    assign big_a = (a > b);
    assign big_b = (b > a);

endmodule

// File: rtl/cmp_stim_checker.sv
// Exhaustive comparator sweep: drives every (a,b) pair for SETTLE cycles, checks responses for one cycle.
// A sweep takes 2^(2*WIDTH)*(SETTLE+1) cycles; start is ignored while busy; all outputs registered.
module cmp_stim_checker
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = CMP_WIDTH_DEF,
    parameter int unsigned SETTLE = CMP_SETTLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 eq_in,
    input  logic                 neq_in,
    input  logic                 big_a_in,
    input  logic                 big_b_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b
);

    localparam int unsigned CW = 2 * WIDTH + 1;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [WIDTH-1:0] OP_MAX = {WIDTH{1'b1}};

    cmp_state_e       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic [CW-1:0]    err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic ref_eq, ref_neq, ref_big_a, ref_big_b;
    logic mismatch;

    cmp_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a     (a_q),
        .b     (b_q),
        .eq    (ref_eq),
        .neq   (ref_neq),
        .big_a (ref_big_a),
        .big_b (ref_big_b)
    );

    assign mismatch = ({eq_in, neq_in, big_a_in, big_b_in} != {ref_eq, ref_neq, ref_big_a, ref_big_b});

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    settle_d = '0;
                    a_d      = '0;
                    b_d      = '0;
                    fa_d     = '0;
                    fb_d     = '0;
                    err_d    = '0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CHECK: begin
                // err_cnt never saturates, so zero means no earlier mismatch in this sweep
                if (mismatch) begin
                    err_d = err_q + CW'(1);
                    if (err_q == '0) begin
                        fa_d = a_q;
                        fb_d = b_q;
                    end
                end
                if (a_q == OP_MAX && b_q == OP_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    b_d     = b_q + 1'b1;
                    if (b_q == OP_MAX) a_d = a_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign first_err_a = fa_q;
    assign first_err_b = fb_q;
    assign err_cnt     = err_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule
